// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider among N_REQ requesters.
// One division in flight at a time; divide-by-zero is answered locally without
// touching the divider.
// Optional feature macro: DIV_ARB_TIMEOUT_EN adds a watchdog on the WAIT state that
// returns an error response after TIMEOUT_CYCLES cycles without div_valid.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | looking for a request; accepts one when the divider is not busy
// ISSUE  | one-cycle div_start pulse with latched operands
// WAIT   | waiting for div_valid (or the watchdog, when enabled)
// RESP   | one-cycle rsp_valid strobe to the granted requester

module div_arbiter #(
    parameter int N_REQ           = 4,
    parameter int N_BITS_DIVIDEND = 32,
    parameter int N_BITS_DIVISOR  = 32,
    parameter int N_BITS_QUOTIENT = 32,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*N_BITS_DIVIDEND-1:0]   req_dividend,
    input  logic [N_REQ*N_BITS_DIVISOR-1:0]    req_divisor,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [N_REQ-1:0]                   rsp_valid,
    output logic [N_BITS_QUOTIENT-1:0]         rsp_quotient,
    output logic                               rsp_error,
    output logic [$clog2(N_REQ)-1:0]           grant_id,
    output logic                               div_start,
    output logic [N_BITS_DIVIDEND-1:0]         div_dividend,
    output logic [N_BITS_DIVISOR-1:0]          div_divisor,
    input  logic [N_BITS_QUOTIENT-1:0]         div_quotient,
    input  logic                               div_busy,
    input  logic                               div_valid
);

    localparam int GW = $clog2(N_REQ);

    if (N_REQ < 2) begin : g_chk_nreq
        $error("div_arbiter: N_REQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("div_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                       state, state_nx;
    logic [GW-1:0]                ptr;
    logic [GW-1:0]                pick;
    logic                         pick_ok;
    int                           idx;
    logic [N_BITS_DIVIDEND-1:0]   pick_dividend;
    logic [N_BITS_DIVISOR-1:0]    pick_divisor;
    logic                         pick_zero;
    logic                         accept;
    logic                         timed_out;

    // Rotating-priority search: first pending requester at or after ptr.
    always_comb begin
        pick    = ptr;
        pick_ok = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!pick_ok && req_valid[idx]) begin
                pick_ok = 1'b1;
                pick    = GW'(idx);
            end
        end
    end

    // Operand mux for the winning requester and accept qualification.
    always_comb begin
        pick_dividend = req_dividend[int'(pick)*N_BITS_DIVIDEND +: N_BITS_DIVIDEND];
        pick_divisor  = req_divisor[int'(pick)*N_BITS_DIVISOR +: N_BITS_DIVISOR];
        pick_zero     = (pick_divisor == '0);
        accept        = (state == S_IDLE) && pick_ok && !div_busy;
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Watchdog: zeroed while issuing so it starts from zero on WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == S_ISSUE)
            wait_cnt <= '0;
        else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timed_out = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    req_ready[pick] = 1'b1;
                    state_nx        = pick_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                if (div_valid || timed_out)
                    state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid[grant_id] = 1'b1;
                state_nx            = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Grant bookkeeping, operand latch and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            grant_id     <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_quotient <= '0;
            rsp_error    <= 1'b0;
        end else begin
            if (accept) begin
                grant_id     <= pick;
                ptr          <= (pick == GW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                div_dividend <= pick_dividend;
                div_divisor  <= pick_divisor;
                if (pick_zero) begin
                    rsp_quotient <= '1;
                    rsp_error    <= 1'b1;
                end
            end
            if (state == S_WAIT) begin
                if (div_valid) begin
                    rsp_quotient <= div_quotient;
                    rsp_error    <= 1'b0;
                end else if (timed_out) begin
                    rsp_quotient <= '1;
                    rsp_error    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter: behavioural divider plus a round-robin reference model.
// Build with DIV_ARB_TIMEOUT_EN defined to exercise the watchdog instead of the
// indefinite WAIT behaviour.

module tb_div_arbiter;

    localparam int N  = 4;
    localparam int WD = 32;
    localparam int WS = 32;
    localparam int WQ = 32;
`ifdef DIV_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*WD-1:0]   req_dividend = '0;
    logic [N*WS-1:0]   req_divisor = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [WQ-1:0]     rsp_quotient;
    logic              rsp_error;
    logic [1:0]        grant_id;
    logic              div_start;
    logic [WD-1:0]     div_dividend;
    logic [WS-1:0]     div_divisor;
    logic [WQ-1:0]     div_quotient;
    logic              div_busy;
    logic              div_valid;

    // Behavioural divider (auto mode) and manual overrides.
    logic              auto_en = 1'b1;
    int                lat = 10;
    logic              m_busy = 1'b0;
    logic              m_valid = 1'b0;
    logic [WQ-1:0]     m_q = '0;
    int                m_rem = 0;
    logic              man_valid = 1'b0;
    logic              man_busy = 1'b0;
    logic [WQ-1:0]     man_q = '0;

    assign div_valid    = m_valid | man_valid;
    assign div_busy     = m_busy | man_busy;
    assign div_quotient = auto_en ? m_q : man_q;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    logic [WD-1:0] dvd [N];
    logic [WS-1:0] dvs [N];

    // Results of the last collect() call.
    int            c_rsp_cyc;
    logic [N-1:0]  c_bits;
    logic [WQ-1:0] c_q;
    logic          c_err;
    int            c_nrsp;
    int            c_nstart;
    int            c_start_cyc;
    logic [1:0]    c_gid1;
    logic [WD-1:0] c_dvd1;
    logic [WS-1:0] c_dvs1;

    div_arbiter #(
        .N_REQ(N), .N_BITS_DIVIDEND(WD), .N_BITS_DIVISOR(WS),
        .N_BITS_QUOTIENT(WQ), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_error(rsp_error), .grant_id(grant_id), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_busy(div_busy), .div_valid(div_valid)
    );

    always #5 clk = ~clk;

    // Divider model: valid arrives lat cycles after the start pulse.
    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (div_start && auto_en) begin
            m_busy <= 1'b1;
            m_rem  <= lat - 2;
            m_q    <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
        end else if (m_busy) begin
            if (m_rem == 0) begin
                m_valid <= 1'b1;
                m_busy  <= 1'b0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Round robin rule: pending requester closest after ptr (inclusive, cyclic).
    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (m[i] && ((i - p + N) % N) < bestd) begin
                bestd = (i - p + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    task automatic load_ops();
        for (int i = 0; i < N; i++) begin
            req_dividend[i*WD +: WD] = dvd[i];
            req_divisor[i*WS +: WS]  = dvs[i];
        end
    endtask

    // Steps cycles after an accept and records what the DUT did; k=1 is the cycle after accept.
    task automatic collect(input int budget, input logic [N-1:0] keep, input int tail);
        c_rsp_cyc = -1; c_bits = '0; c_q = '0; c_err = 1'b0;
        c_nrsp = 0; c_nstart = 0; c_start_cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = req_valid & keep;
                if (keep == '0) begin
                    req_dividend = ~req_dividend;
                    req_divisor  = ~req_divisor;
                end
            end
            #1;
            if (k == 1) begin
                c_gid1 = grant_id; c_dvd1 = div_dividend; c_dvs1 = div_divisor;
            end
            if (div_start) begin
                c_nstart++;
                if (c_start_cyc < 0) c_start_cyc = k;
            end
            if (rsp_valid != '0) begin
                c_nrsp++;
                if (c_rsp_cyc < 0) begin
                    c_rsp_cyc = k; c_bits = rsp_valid; c_q = rsp_quotient; c_err = rsp_error;
                end
            end
            if (c_rsp_cyc > 0 && k >= c_rsp_cyc + tail) break;
        end
    endtask

    task automatic test_reset();
        int act;
        rst = 1'b1; req_valid = '0;
        @(negedge clk); #1;
        n_checks++;
        if ({req_ready, rsp_valid, div_start} !== '0) begin
            n_fail++; $display("FAIL reset_strobes: got %0h expected 0", {req_ready, rsp_valid, div_start});
        end
        n_checks++;
        if ({rsp_quotient, rsp_error, grant_id} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got %0h expected 0", {rsp_quotient, rsp_error, grant_id});
        end
        n_checks++;
        if ({div_dividend, div_divisor} !== '0) begin
            n_fail++; $display("FAIL reset_operands: got %0h expected 0", {div_dividend, div_divisor});
        end
        @(negedge clk); rst = 1'b0; m_ptr = 0;
        act = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (req_ready != '0 || rsp_valid != '0 || div_start) act++;
        end
        n_checks++;
        if (act !== 0) begin
            n_fail++; $display("FAIL reset_idle_quiet: got %0d active cycles expected 0", act);
        end
    endtask

    task automatic test_single();
        auto_en = 1'b1; lat = 10;
        @(negedge clk);
        dvd[0] = 100; dvs[0] = 7;
        for (int i = 1; i < N; i++) begin dvd[i] = $urandom; dvs[i] = 3; end
        load_ops();
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        collect(60, '0, 2);
        n_checks++;
        if (c_rsp_cyc !== 12) begin
            n_fail++; $display("FAIL single_latency: got %0d expected 12", c_rsp_cyc);
        end
        n_checks++;
        if (c_bits !== 4'b0001 || c_q !== 32'd14 || c_err !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: got bits %b q %0d err %b expected 0001 14 0", c_bits, c_q, c_err);
        end
        n_checks++;
        if (c_nstart !== 1 || c_start_cyc !== 1) begin
            n_fail++; $display("FAIL single_start: got %0d pulses at %0d expected 1 at 1", c_nstart, c_start_cyc);
        end
        n_checks++;
        if (c_dvd1 !== 32'd100 || c_dvs1 !== 32'd7) begin
            n_fail++; $display("FAIL single_operands: got %0d/%0d expected 100/7", c_dvd1, c_dvs1);
        end
        m_ptr = 1;
    endtask

    task automatic test_fairness();
        int order [6] = '{0, 1, 2, 3, 0, 2};
        logic [N-1:0] pending;
        int w;
        int g;
        auto_en = 1'b1; lat = int'($urandom_range(2, 6));
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin dvd[i] = $urandom; dvs[i] = $urandom_range(1, 1000); end
        load_ops();
        req_valid = 4'b1111; pending = 4'b1111;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; m_ptr = 0;
        #1;
        for (int r = 0; r < 6; r++) begin
            if (r == 4) begin pending = 4'b0101; req_valid = pending; end
            w = 0;
            while (req_ready == '0 && w < 50) begin @(negedge clk); #1; w++; end
            g = order[r];
            n_checks++;
            if (req_ready !== onehot(g)) begin
                n_fail++; $display("FAIL fair_grant_%0d: got %b expected %b", r, req_ready, onehot(g));
            end
            collect(60, ~onehot(g), 0);
            pending = pending & ~onehot(g);
            n_checks++;
            if (c_bits !== onehot(g) || int'(c_gid1) !== g) begin
                n_fail++; $display("FAIL fair_rsp_%0d: got bits %b gid %0d expected %b %0d", r, c_bits, c_gid1, onehot(g), g);
            end
            n_checks++;
            if (c_q !== dvd[g] / dvs[g]) begin
                n_fail++; $display("FAIL fair_quot_%0d: got %0d expected %0d", r, c_q, dvd[g] / dvs[g]);
            end
            m_ptr = (g + 1) % N;
        end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        dvd[2] = 55; dvs[2] = 0;
        load_ops();
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== onehot(rr_pick(4'b0100, m_ptr))) begin
            n_fail++; $display("FAIL dz_ready: got %b expected 0100", req_ready);
        end
        collect(20, '0, 2);
        n_checks++;
        if (c_rsp_cyc !== 1 || c_bits !== 4'b0100) begin
            n_fail++; $display("FAIL dz_timing: got cyc %0d bits %b expected 1 0100", c_rsp_cyc, c_bits);
        end
        n_checks++;
        if (c_err !== 1'b1 || c_q !== 32'hFFFF_FFFF || c_nstart !== 0) begin
            n_fail++; $display("FAIL dz_rsp: got err %b q %h starts %0d expected 1 ffffffff 0", c_err, c_q, c_nstart);
        end
        m_ptr = 3;
    endtask

    task automatic test_stale_valid();
        int pre;
        int n;
        int cyc;
        logic [N-1:0] bits;
        logic [WQ-1:0] q;
        logic err;
        logic st1;
        auto_en = 1'b0; man_q = 32'hDEAD;
        pre = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); man_valid = (k == 0); #1;
            if (rsp_valid != '0) pre++;
        end
        n_checks++;
        if (pre !== 0) begin
            n_fail++; $display("FAIL stale_idle: got %0d responses expected 0", pre);
        end
        @(negedge clk);
        dvd[1] = 1000; dvs[1] = 10;
        load_ops();
        req_valid = 4'b0010; man_valid = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL stale_ready: got %b expected 0010", req_ready);
        end
        n = 0; cyc = -1; bits = '0; q = '0; err = 1'b0; st1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = '0;
            man_valid = (k == 1) || (k == 5);
            man_q = (k == 5) ? 32'd100 : 32'hDEAD;
            #1;
            if (k == 1) st1 = div_start;
            if (rsp_valid != '0) begin
                n++;
                if (cyc < 0) begin cyc = k; bits = rsp_valid; q = rsp_quotient; err = rsp_error; end
            end
        end
        n_checks++;
        if (n !== 1 || cyc !== 6 || st1 !== 1'b1) begin
            n_fail++; $display("FAIL stale_count: got %0d rsp at %0d start %b expected 1 at 6 start 1", n, cyc, st1);
        end
        n_checks++;
        if (bits !== 4'b0010 || q !== 32'd100 || err !== 1'b0) begin
            n_fail++; $display("FAIL stale_rsp: got bits %b q %0d err %b expected 0010 100 0", bits, q, err);
        end
        man_valid = 1'b0; auto_en = 1'b1;
        m_ptr = 2;
    endtask

    task automatic test_reset_midop();
        int early;
        auto_en = 1'b1; lat = 20;
        @(negedge clk);
        dvd[3] = 77; dvs[3] = 7;
        load_ops();
        req_valid = 4'b1000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL midrst_ready: got %b expected 1000", req_ready);
        end
        @(negedge clk); req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1; man_busy = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, div_start, grant_id} !== '0) begin
            n_fail++; $display("FAIL midrst_ctrl: got %h expected 0", {req_ready, rsp_valid, div_start, grant_id});
        end
        n_checks++;
        if ({div_dividend, div_divisor, rsp_quotient, rsp_error} !== '0) begin
            n_fail++; $display("FAIL midrst_data: got %h expected 0", {div_dividend, div_divisor});
        end
        @(negedge clk);
        rst = 1'b0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin dvd[i] = $urandom; dvs[i] = $urandom_range(1, 50000); end
        load_ops();
        req_valid = 4'b1111;
        early = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (req_ready != '0) early++;
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++; $display("FAIL midrst_busy_gate: got %0d grants expected 0", early);
        end
        @(negedge clk); man_busy = 1'b0; #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_first_grant: got %b expected 0001", req_ready);
        end
        lat = 5;
        collect(60, '0, 2);
        n_checks++;
        if (c_bits !== 4'b0001 || c_q !== dvd[0] / dvs[0]) begin
            n_fail++; $display("FAIL midrst_rsp: got bits %b q %0d expected 0001 %0d", c_bits, c_q, dvd[0] / dvs[0]);
        end
        m_ptr = 1;
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int g;
        int exp_cyc;
        logic [WQ-1:0] exp_q;
        logic exp_err;
        int exp_st;
        auto_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                dvd[i] = $urandom;
                dvs[i] = ($urandom_range(0, 7) == 0) ? '0 : WS'($urandom_range(1, 70000));
            end
            lat = int'($urandom_range(2, 12));
            @(negedge clk);
            load_ops();
            req_valid = mask;
            #1;
            g = rr_pick(mask, m_ptr);
            n_checks++;
            if (req_ready !== onehot(g)) begin
                n_fail++; $display("FAIL rnd_grant_%0d: got %b expected %b", it, req_ready, onehot(g));
            end
            collect(80, '0, 2);
            n_checks++;
            if (int'(c_gid1) !== g || c_dvd1 !== dvd[g] || c_dvs1 !== dvs[g]) begin
                n_fail++; $display("FAIL rnd_latch_%0d: got %0d %h/%h expected %0d %h/%h", it, c_gid1, c_dvd1, c_dvs1, g, dvd[g], dvs[g]);
            end
            if (dvs[g] == 0) begin
                exp_cyc = 1; exp_q = '1; exp_err = 1'b1; exp_st = 0;
            end else begin
                exp_cyc = lat + 2; exp_q = dvd[g] / dvs[g]; exp_err = 1'b0; exp_st = 1;
            end
            n_checks++;
            if (c_rsp_cyc !== exp_cyc || c_nrsp !== 1 || c_nstart !== exp_st) begin
                n_fail++; $display("FAIL rnd_timing_%0d: got cyc %0d n %0d st %0d expected %0d 1 %0d", it, c_rsp_cyc, c_nrsp, c_nstart, exp_cyc, exp_st);
            end
            n_checks++;
            if (c_bits !== onehot(g) || c_q !== exp_q || c_err !== exp_err) begin
                n_fail++; $display("FAIL rnd_rsp_%0d: got %b %h %b expected %b %h %b", it, c_bits, c_q, c_err, onehot(g), exp_q, exp_err);
            end
            m_ptr = (g + 1) % N;
        end
    endtask

`ifdef DIV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int cyc;
        logic [WQ-1:0] q;
        logic err;
        auto_en = 1'b0; man_q = 32'd5;
        @(negedge clk);
        dvd[0] = 9; dvs[0] = 3;
        load_ops();
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL to_ready: got %b expected 0001", req_ready);
        end
        n = 0; cyc = -1; q = '0; err = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = '0;
            man_valid = (k == 22);
            #1;
            if (rsp_valid != '0) begin
                n++;
                if (cyc < 0) begin cyc = k; q = rsp_quotient; err = rsp_error; end
            end
        end
        n_checks++;
        if (cyc !== TO + 2 || n !== 1) begin
            n_fail++; $display("FAIL to_timing: got %0d rsp at %0d expected 1 at %0d", n, cyc, TO + 2);
        end
        n_checks++;
        if (err !== 1'b1 || q !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL to_rsp: got err %b q %h expected 1 ffffffff", err, q);
        end
        man_valid = 1'b0; auto_en = 1'b1;
        m_ptr = 1;
    endtask
`else
    task automatic test_no_timeout();
        int n;
        int cyc;
        logic [WQ-1:0] q;
        logic err;
        auto_en = 1'b0; man_q = 32'd5;
        @(negedge clk);
        dvd[0] = 9; dvs[0] = 3;
        load_ops();
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL nto_ready: got %b expected 0001", req_ready);
        end
        n = 0; cyc = -1; q = '0; err = 1'b1;
        for (int k = 1; k <= 305; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = '0;
            man_valid = (k == 300);
            #1;
            if (rsp_valid != '0) begin
                n++;
                if (cyc < 0) begin cyc = k; q = rsp_quotient; err = rsp_error; end
            end
        end
        n_checks++;
        if (cyc !== 301 || n !== 1) begin
            n_fail++; $display("FAIL nto_timing: got %0d rsp at %0d expected 1 at 301", n, cyc);
        end
        n_checks++;
        if (err !== 1'b0 || q !== 32'd5) begin
            n_fail++; $display("FAIL nto_rsp: got err %b q %0d expected 0 5", err, q);
        end
        man_valid = 1'b0; auto_en = 1'b1;
        m_ptr = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_div_zero();
        test_stale_valid();
        test_reset_midop();
        test_random();
`ifdef DIV_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
